// File: rtl/palette_pkg.sv
// ============================================================================
// Module : palette_pkg
// Shared constants and types for the PPU palette controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package palette_pkg;
  localparam int RGB_BIT    = 12;
  localparam int PAL_ADDR_W = 4;
  localparam int N_ENTRY    = 16;
  localparam int N_REQ      = 2;

  localparam logic [PAL_ADDR_W-1:0] LAST_ENTRY = PAL_ADDR_W'(N_ENTRY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_e;

  localparam logic REQ_BG = 1'b0;
  localparam logic REQ_SP = 1'b1;
endpackage

`default_nettype wire

// File: rtl/palette_rr_arb.sv
// ============================================================================
// Module : palette_rr_arb
// Two-way round-robin arbiter with a hold-off input that blocks all grants.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_rr_arb
  import palette_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             hold_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic lastGnt_q;

  always_comb begin
    gnt_o = '0;
    if (!hold_i) begin
      if (req_i[REQ_BG] && req_i[REQ_SP]) begin
        // Contention goes to whoever was not served last.
        gnt_o[REQ_SP] = (lastGnt_q == REQ_BG);
        gnt_o[REQ_BG] = (lastGnt_q == REQ_SP);
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGnt_q <= REQ_BG;
    end else if (|gnt_o) begin
      lastGnt_q <= gnt_o[REQ_SP] ? REQ_SP : REQ_BG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/palette_ctrl.sv
// ============================================================================
// Module : palette_ctrl
// Shadow/active palette tables with vblank-gated commit and a shared read port.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_ctrl #(
  parameter int RGB_BIT = palette_pkg::RGB_BIT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpuWrEn,
  input  logic [palette_pkg::PAL_ADDR_W-1:0] cpuWrAddr,
  input  logic [RGB_BIT-1:0]                cpuWrData,
  input  logic                              cpuCommit,
  input  logic                              vblank,
  output logic                              commitBusy,
  output logic                              commitDone,
  input  logic                              bgReq,
  input  logic [1:0]                        bgPalette,
  input  logic [1:0]                        bgIdx,
  output logic                              bgGnt,
  output logic                              bgValid,
  output logic [RGB_BIT-1:0]                bgColor,
  input  logic                              spReq,
  input  logic [1:0]                        spPalette,
  input  logic [1:0]                        spIdx,
  output logic                              spGnt,
  output logic                              spValid,
  output logic [RGB_BIT-1:0]                spColor
);
  import palette_pkg::*;

  logic [RGB_BIT-1:0]    shadow_q [N_ENTRY];
  logic [RGB_BIT-1:0]    active_q [N_ENTRY];
  state_e                state_q;
  logic                  pending_q;
  logic [PAL_ADDR_W-1:0] cnt_q;
  logic                  commitDone_q;
  logic                  bgValid_q, spValid_q;
  logic [RGB_BIT-1:0]    bgColor_q, spColor_q;
  logic [N_REQ-1:0]      w_req, w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRY; i++) shadow_q[i] <= '0;
    end else if (cpuWrEn) begin
      shadow_q[cpuWrAddr] <= cpuWrData;
    end
  end

  // A write landing on the entry being copied loses: the copy reads the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      commitDone_q <= 1'b0;
      for (int i = 0; i < N_ENTRY; i++) active_q[i] <= '0;
    end else begin
      commitDone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q && vblank) begin
            state_q   <= ST_COPY;
            cnt_q     <= '0;
            pending_q <= cpuCommit;
          end else if (cpuCommit) begin
            pending_q <= 1'b1;
          end
        end
        ST_COPY: begin
          active_q[cnt_q] <= shadow_q[cnt_q];
          cnt_q           <= cnt_q + 1'b1;
          if (cpuCommit) pending_q <= 1'b1;
          if (cnt_q == LAST_ENTRY) begin
            state_q      <= ST_IDLE;
            commitDone_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_req[REQ_BG] = bgReq;
  assign w_req[REQ_SP] = spReq;

  palette_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (w_req),
    .hold_i (state_q == ST_COPY),
    .gnt_o  (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bgValid_q <= 1'b0;
      spValid_q <= 1'b0;
      bgColor_q <= '0;
      spColor_q <= '0;
    end else begin
      bgValid_q <= w_gnt[REQ_BG];
      spValid_q <= w_gnt[REQ_SP];
      if (w_gnt[REQ_BG]) bgColor_q <= active_q[{bgPalette, bgIdx}];
      if (w_gnt[REQ_SP]) spColor_q <= active_q[{spPalette, spIdx}];
    end
  end

  assign commitBusy = pending_q | (state_q == ST_COPY);
  assign commitDone = commitDone_q;
  assign bgGnt      = w_gnt[REQ_BG];
  assign spGnt      = w_gnt[REQ_SP];
  assign bgValid    = bgValid_q;
  assign spValid    = spValid_q;
  assign bgColor    = bgColor_q;
  assign spColor    = spColor_q;

endmodule

`default_nettype wire

// File: tb/tb_palette_ctrl.sv
// ============================================================================
// Module : tb_palette_ctrl
// Directed, table-driven checks of palette_ctrl commit, arbitration and reads.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palette_ctrl;
  localparam int RGB_BIT = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cpuWrEn, cpuCommit, vblank;
  logic [3:0]         cpuWrAddr;
  logic [RGB_BIT-1:0] cpuWrData;
  logic               commitBusy, commitDone;
  logic               bgReq, spReq, bgGnt, spGnt, bgValid, spValid;
  logic [1:0]         bgPalette, bgIdx, spPalette, spIdx;
  logic [RGB_BIT-1:0] bgColor, spColor;

  palette_ctrl #(.RGB_BIT(RGB_BIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuWrEn(cpuWrEn), .cpuWrAddr(cpuWrAddr), .cpuWrData(cpuWrData),
    .cpuCommit(cpuCommit), .vblank(vblank),
    .commitBusy(commitBusy), .commitDone(commitDone),
    .bgReq(bgReq), .bgPalette(bgPalette), .bgIdx(bgIdx),
    .bgGnt(bgGnt), .bgValid(bgValid), .bgColor(bgColor),
    .spReq(spReq), .spPalette(spPalette), .spIdx(spIdx),
    .spGnt(spGnt), .spValid(spValid), .spColor(spColor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       bq;
    logic [1:0] bp, bi;
    logic       sq;
    logic [1:0] sp, si;
    logic       eBg, eSp;
    logic [11:0] eBc, eSc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Colour written to shadow entry k; entry 5 is the 0xF80 test value.
  function automatic logic [11:0] col(input int k);
    logic [3:0] kk;
    kk = k[3:0];
    return (k == 5) ? 12'hF80 : {kk, 4'hF - kk, 4'hA};
  endfunction

  function automatic vec_t mk(input logic bq, input logic [1:0] bp, input logic [1:0] bi,
                              input logic sq, input logic [1:0] sp, input logic [1:0] si,
                              input logic eBg, input logic eSp,
                              input logic [11:0] eBc, input logic [11:0] eSc);
    vec_t v;
    v.bq = bq; v.bp = bp; v.bi = bi;
    v.sq = sq; v.sp = sp; v.si = si;
    v.eBg = eBg; v.eSp = eSp; v.eBc = eBc; v.eSc = eSc;
    return v;
  endfunction

  initial begin
    int busyCnt, doneCnt, doneAt, lastBusyAt;

    // After the commit active == shadow; lastGnt becomes BG at vector 0.
    vecs[0]  = mk(1, 0, 3, 0, 0, 0, 1, 0, 12'h3CA, 12'hF80);
    vecs[1]  = mk(1, 2, 2, 1, 3, 0, 0, 1, 12'h3CA, 12'hC3A);
    vecs[2]  = mk(1, 2, 2, 1, 3, 0, 1, 0, 12'hA5A, 12'hC3A);
    vecs[3]  = mk(1, 2, 2, 1, 3, 0, 0, 1, 12'hA5A, 12'hC3A);
    vecs[4]  = mk(1, 2, 2, 1, 3, 0, 1, 0, 12'hA5A, 12'hC3A);
    vecs[5]  = mk(1, 2, 2, 1, 3, 0, 0, 1, 12'hA5A, 12'hC3A);
    vecs[6]  = mk(1, 2, 2, 1, 3, 0, 1, 0, 12'hA5A, 12'hC3A);
    vecs[7]  = mk(1, 2, 2, 1, 3, 0, 0, 1, 12'hA5A, 12'hC3A);
    vecs[8]  = mk(1, 2, 2, 1, 3, 0, 1, 0, 12'hA5A, 12'hC3A);
    vecs[9]  = mk(0, 2, 2, 0, 3, 0, 0, 0, 12'hA5A, 12'hC3A);
    vecs[10] = mk(0, 2, 2, 1, 0, 0, 0, 1, 12'hA5A, 12'h0FA);

    rst_n = 1'b0; cpuWrEn = 1'b0; cpuWrAddr = '0; cpuWrData = '0;
    cpuCommit = 1'b0; vblank = 1'b0;
    bgReq = 1'b0; bgPalette = '0; bgIdx = '0;
    spReq = 1'b0; spPalette = '0; spIdx = '0;
    #2;
    chk("rst_busy", commitBusy, 0);
    chk("rst_done", commitDone, 0);
    chk("rst_bgValid", bgValid, 0);
    chk("rst_spValid", spValid, 0);
    chk("rst_bgColor", bgColor, 0);
    chk("rst_spColor", spColor, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single BG lookup: grant same cycle, data next cycle.
    bgReq = 1'b1; bgPalette = 2'd2; bgIdx = 2'd1;
    #1;
    chk("bg_first_gnt", bgGnt, 1);
    chk("bg_first_spGnt", spGnt, 0);
    tick();
    bgReq = 1'b0;
    chk("bg_first_valid", bgValid, 1);
    chk("bg_first_color", bgColor, 12'h000);
    tick();
    chk("bg_first_valid_drop", bgValid, 0);

    for (int k = 0; k < 16; k++) begin
      cpuWrEn = 1'b1; cpuWrAddr = 4'(k); cpuWrData = col(k);
      tick();
    end
    cpuWrEn = 1'b0;

    // Shadow writes must not reach the active table before a commit.
    spReq = 1'b1; spPalette = 2'd1; spIdx = 2'd1;
    #1;
    chk("sp_pre_gnt", spGnt, 1);
    tick();
    spReq = 1'b0;
    chk("sp_pre_color", spColor, 12'h000);

    cpuCommit = 1'b1; vblank = 1'b1;
    tick();
    cpuCommit = 1'b0;
    busyCnt = 0; doneCnt = 0; doneAt = -1; lastBusyAt = -1;
    for (int i = 0; i < 40; i++) begin
      if (commitBusy) begin busyCnt++; lastBusyAt = i; end
      if (commitDone) begin doneCnt++; doneAt = i; end
      tick();
    end
    vblank = 1'b0;
    chk("commit_busy_cycles", busyCnt, 17);
    chk("commit_done_pulses", doneCnt, 1);
    chk("commit_done_after_busy", doneAt, lastBusyAt + 1);

    spReq = 1'b1;
    #1;
    chk("sp_post_gnt", spGnt, 1);
    tick();
    spReq = 1'b0;
    chk("sp_post_color", spColor, 12'hF80);

    for (int i = 0; i < 11; i++) begin
      bgReq = vecs[i].bq; bgPalette = vecs[i].bp; bgIdx = vecs[i].bi;
      spReq = vecs[i].sq; spPalette = vecs[i].sp; spIdx = vecs[i].si;
      #1;
      chk($sformatf("vec%0d_bgGnt", i), bgGnt, vecs[i].eBg);
      chk($sformatf("vec%0d_spGnt", i), spGnt, vecs[i].eSp);
      tick();
      chk($sformatf("vec%0d_bgValid", i), bgValid, vecs[i].eBg);
      chk($sformatf("vec%0d_spValid", i), spValid, vecs[i].eSp);
      chk($sformatf("vec%0d_bgColor", i), bgColor, vecs[i].eBc);
      chk($sformatf("vec%0d_spColor", i), spColor, vecs[i].eSc);
    end
    bgReq = 1'b0; spReq = 1'b0;

    // Commit without vblank stays pending indefinitely.
    bgPalette = 2'd3; bgIdx = 2'd3;
    cpuCommit = 1'b1;
    tick();
    cpuCommit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("pend_busy", commitBusy, 1);
      tick();
    end
    bgReq = 1'b1; vblank = 1'b1;
    #1;
    chk("pend_idle_gnt", bgGnt, 1);
    tick();
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("copy%0d_bgGnt", c), bgGnt, 0);
      chk($sformatf("copy%0d_busy", c), commitBusy, 1);
      if (c == 3) vblank = 1'b0;
      tick();
    end
    chk("copy_end_done", commitDone, 1);
    chk("copy_end_bgGnt", bgGnt, 1);
    chk("copy_end_busy", commitBusy, 0);
    tick();
    bgReq = 1'b0;
    chk("copy_end_bgValid", bgValid, 1);
    chk("copy_end_bgColor", bgColor, 12'hF0A);
    chk("copy_end_done_drop", commitDone, 0);

    // Reset in the middle of a copy.
    cpuWrEn = 1'b1; cpuWrAddr = 4'd3; cpuWrData = 12'h123;
    tick();
    cpuWrEn = 1'b0;
    cpuCommit = 1'b1; vblank = 1'b1;
    tick();
    cpuCommit = 1'b0;
    tick();
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", commitBusy, 0);
    chk("midrst_done", commitDone, 0);
    chk("midrst_bgValid", bgValid, 0);
    chk("midrst_spValid", spValid, 0);
    chk("midrst_bgColor", bgColor, 0);
    chk("midrst_spColor", spColor, 0);
    #2;
    rst_n = 1'b1;
    tick();
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (commitDone || commitBusy) doneCnt++;
      tick();
    end
    chk("midrst_no_resume", doneCnt, 0);
    vblank = 1'b0;
    bgReq = 1'b1; bgPalette = 2'd0; bgIdx = 2'd3;
    #1;
    chk("midrst_read_gnt", bgGnt, 1);
    tick();
    bgReq = 1'b0;
    chk("midrst_read_valid", bgValid, 1);
    chk("midrst_read_color", bgColor, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
